trap_ctrl: RTL

Commit-stage trap sequencer for the machine-mode CSR file. It watches each committing instruction for exceptions, `mret` and enabled pending interrupts, and picks one event by fixed priority. It drains outstanding memory traffic, then issues a single-cycle trap or `mret` update command to the CSR file, and finally hands a redirect PC to fetch with a valid/ready handshake. The pipeline flush is held for the whole sequence.

---
 rtl/trap_ctrl_if.sv | 25 ++
 rtl/trap_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: commit-stage event bus and fetch redirect handshake between the pipeline and trap_ctrl.
interface trap_ctrl_if #(parameter int XLEN = 64);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            commit_ecall;
  logic            commit_misalign;
  logic            commit_illegal;
  logic            commit_mret;
  logic [XLEN-1:0] commit_tval;
  logic            commit_ready;
  logic            commit_kill;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  modport master (
    output commit_valid, commit_pc, commit_ecall, commit_misalign, commit_illegal, commit_mret,
           commit_tval, redirect_ready,
    input  commit_ready, commit_kill, redirect_valid, redirect_pc
  );
  modport slave (
    input  commit_valid, commit_pc, commit_ecall, commit_misalign, commit_illegal, commit_mret,
           commit_tval, redirect_ready,
    output commit_ready, commit_kill, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap/mret sequencer that drains memory, pulses the CSR update and redirects fetch.
module trap_ctrl #(
  parameter int XLEN          = 64,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            reset,
  trap_ctrl_if.slave      bus,
  input  logic [XLEN-1:0] mip_in,
  input  logic [XLEN-1:0] mie_in,
  input  logic            mstatus_mie,
  input  logic [1:0]      priv_mode,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            mem_busy,
  output logic            trap_we,
  output logic [XLEN-1:0] trap_cause,
  output logic [XLEN-1:0] trap_epc,
  output logic [XLEN-1:0] trap_tval,
  output logic            mret_we,
  output logic            flush,
  output logic            drain_timeout,
  output logic [31:0]     trap_cnt
);
  localparam int CW = DRAIN_TIMEOUT > 1 ? $clog2(DRAIN_TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, DRAIN, UPDATE, REDIRECT} state_t;
  state_t          state;
  logic [CW-1:0]   cnt;
  logic            kind_mret;
  logic            kind_irq;
  logic [3:0]      code_q;
  logic            ready_q;
  logic            rvalid_q;
  logic [XLEN-1:0] rpc_q;
  logic            mei, msi, mti;
  logic            irq;
  logic            trap_ev;
  logic            ev;
  logic [3:0]      code;
  logic [XLEN-1:0] cause_n;
  logic [XLEN-1:0] tval_n;
  logic [XLEN-1:0] base;
  logic            at_limit;
  always_comb begin
    mei      = mip_in[11] & mie_in[11];
    msi      = mip_in[3] & mie_in[3];
    mti      = mip_in[7] & mie_in[7];
    irq      = (mei | msi | mti) & (mstatus_mie | (priv_mode != 2'd3));
    code     = mei ? 4'd11 : msi ? 4'd3 : 4'd7;
    trap_ev  = irq | bus.commit_misalign | bus.commit_illegal | bus.commit_ecall;
    ev       = bus.commit_valid & (trap_ev | bus.commit_mret);
    cause_n  = irq                 ? {1'b1, {(XLEN-5){1'b0}}, code} :
               bus.commit_misalign ? '0 :
               bus.commit_illegal  ? XLEN'(2) :
               bus.commit_ecall    ? XLEN'(4'd8 + {2'b00, priv_mode}) : '0;
    tval_n   = (!irq && (bus.commit_misalign || bus.commit_illegal)) ? bus.commit_tval : '0;
    base     = {mtvec_in[XLEN-1:2], 2'b00};
    at_limit = cnt == CW'(DRAIN_TIMEOUT - 1);
  end
  // mret retires normally; only trap-class events suppress the instruction
  assign bus.commit_kill    = (state == IDLE) & bus.commit_valid & trap_ev;
  assign bus.commit_ready   = ready_q;
  assign bus.redirect_valid = rvalid_q;
  assign bus.redirect_pc    = rpc_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      cnt           <= '0;
      kind_mret     <= 1'b0;
      kind_irq      <= 1'b0;
      code_q        <= '0;
      ready_q       <= 1'b1;
      rvalid_q      <= 1'b0;
      rpc_q         <= '0;
      trap_we       <= 1'b0;
      mret_we       <= 1'b0;
      trap_cause    <= '0;
      trap_epc      <= '0;
      trap_tval     <= '0;
      flush         <= 1'b0;
      drain_timeout <= 1'b0;
      trap_cnt      <= '0;
    end else begin
      trap_we <= 1'b0;
      mret_we <= 1'b0;
      case (state)
        IDLE: if (ev) begin
          state      <= DRAIN;
          flush      <= 1'b1;
          ready_q    <= 1'b0;
          cnt        <= '0;
          kind_mret  <= !trap_ev;
          kind_irq   <= irq;
          code_q     <= code;
          trap_cause <= cause_n;
          trap_epc   <= bus.commit_pc;
          trap_tval  <= tval_n;
        end
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (!mem_busy || at_limit) begin
            state   <= UPDATE;
            trap_we <= !kind_mret;
            mret_we <= kind_mret;
            if (mem_busy) drain_timeout <= 1'b1;
          end
        end
        UPDATE: begin
          state    <= REDIRECT;
          rvalid_q <= 1'b1;
          rpc_q    <= kind_mret ? mepc_in :
                      (mtvec_in[1:0] == 2'd1 && kind_irq) ? base + XLEN'({code_q, 2'b00}) : base;
          if (!kind_mret) trap_cnt <= trap_cnt + 1'b1;
        end
        REDIRECT: if (bus.redirect_ready) begin
          state    <= IDLE;
          rvalid_q <= 1'b0;
          flush    <= 1'b0;
          ready_q  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
